// File: rtl/keypad_digit_scanner.sv
// Scans an active-low 4x3 membrane keypad one column at a time, debounces presses
// and releases, and emits one digit / start / stop strobe per accepted press.
module keypad_digit_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [3:0] set_time_digit,
    output logic       digit_valid,
    output logic       start_key,
    output logic       stop_key
);

    // state       | meaning
    // ST_SCAN     | rotating columns, waiting for a single-row sample
    // ST_DEBOUNCE | column frozen, counting consecutive samples of the latched row
    // ST_HELD     | key accepted and strobed, waiting for the keypad to go idle
    // ST_RELEASE  | counting consecutive idle samples before scanning resumes
    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DB_LAST  = 4'(DEBOUNCE_SCANS);
    localparam logic [3:0]      KEY_STAR = 4'hA;
    localparam logic [3:0]      KEY_HASH = 4'hB;

    state_t           state;
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic             scan_tick;
    logic [3:0]       row_low;
    logic             samp_idle;
    logic             samp_valid;
    logic [1:0]       samp_row;
    logic [1:0]       lat_row;
    logic [1:0]       cur_col;
    logic [2:0]       col_rot;
    logic [3:0]       stable_cnt;
    logic [3:0]       cnt_inc;
    logic             same_row;
    logic [3:0]       emit_code;
    logic             fire;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
        if (r == 2'd3) begin
            case (c)
                2'd0:    k = KEY_STAR;
                2'd1:    k = 4'd0;
                default: k = KEY_HASH;
            endcase
        end
        return k;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign scan_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= scan_tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    assign row_low    = ~row_sync;
    assign samp_idle  = (row_low == 4'b0000);
    assign samp_valid = !samp_idle && ((row_low & (row_low - 4'd1)) == 4'b0000);

    always_comb begin
        case (row_low)
            4'b0010: samp_row = 2'd1;
            4'b0100: samp_row = 2'd2;
            4'b1000: samp_row = 2'd3;
            default: samp_row = 2'd0;
        endcase
    end

    always_comb begin
        case (col_out)
            3'b110:  cur_col = 2'd0;
            3'b101:  cur_col = 2'd1;
            default: cur_col = 2'd2;
        endcase
    end

    // Active-low one-hot rotate: 110 -> 101 -> 011 -> 110.
    assign col_rot   = {col_out[1:0], col_out[2]};
    assign cnt_inc   = (stable_cnt >= DB_LAST) ? DB_LAST : stable_cnt + 4'd1;
    assign same_row  = samp_valid && (samp_row == lat_row);
    // The column is frozen outside ST_SCAN, so the driven column is the latched one.
    assign emit_code = key_code((state == ST_SCAN) ? samp_row : lat_row, cur_col);

    always_comb begin
        fire = 1'b0;
        if (scan_tick) begin
            case (state)
                ST_SCAN:     fire = samp_valid && (DB_LAST == 4'd1);
                ST_DEBOUNCE: fire = same_row && (cnt_inc == DB_LAST);
                default:     fire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_SCAN;
            col_out        <= 3'b110;
            lat_row        <= '0;
            stable_cnt     <= '0;
            set_time_digit <= 4'hF;
            digit_valid    <= 1'b0;
            start_key      <= 1'b0;
            stop_key       <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            start_key   <= 1'b0;
            stop_key    <= 1'b0;

            if (scan_tick) begin
                case (state)
                    ST_SCAN: begin
                        if (samp_valid) begin
                            lat_row    <= samp_row;
                            stable_cnt <= 4'd1;
                            state      <= fire ? ST_HELD : ST_DEBOUNCE;
                        end else begin
                            col_out <= col_rot;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (samp_idle) begin
                            state   <= ST_SCAN;
                            col_out <= col_rot;
                        end else if (same_row) begin
                            stable_cnt <= cnt_inc;
                            if (fire) begin
                                state <= ST_HELD;
                            end
                        end else if (samp_valid) begin
                            lat_row    <= samp_row;
                            stable_cnt <= 4'd1;
                        end else begin
                            stable_cnt <= 4'd0;
                        end
                    end
                    ST_HELD: begin
                        if (samp_idle) begin
                            stable_cnt <= 4'd1;
                            if (DB_LAST == 4'd1) begin
                                state   <= ST_SCAN;
                                col_out <= col_rot;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end
                    end
                    default: begin
                        if (samp_idle) begin
                            stable_cnt <= cnt_inc;
                            if (cnt_inc == DB_LAST) begin
                                state   <= ST_SCAN;
                                col_out <= col_rot;
                            end
                        end else begin
                            state <= ST_HELD;
                        end
                    end
                endcase
            end

            if (fire) begin
                if (emit_code <= 4'd9) begin
                    set_time_digit <= emit_code;
                    digit_valid    <= 1'b1;
                end else if (emit_code == KEY_HASH) begin
                    start_key <= 1'b1;
                end else begin
                    stop_key <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_digit_scanner.sv
// Directed bench for keypad_digit_scanner with a behavioral membrane keypad model.
`timescale 1ns/1ps
module tb_keypad_digit_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_in;
    logic [2:0]  col_out;
    logic [3:0]  set_time_digit;
    logic        digit_valid;
    logic        start_key;
    logic        stop_key;
    logic [11:0] pressed = '0;

    keypad_digit_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .row_in         (row_in),
        .col_out        (col_out),
        .set_time_digit (set_time_digit),
        .digit_valid    (digit_valid),
        .start_key      (start_key),
        .stop_key       (stop_key)
    );

    always #5 clk = ~clk;

    // Key (r,c) is bit r*3+c of pressed; it pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    ev_t  evq[$];
    int   onsetq[$];
    int   run3q[$];
    int   cyc = 0;
    int   multi_hits = 0;
    int   run = 0;
    logic prev_valid = 1'b0;
    logic [3:0] r_d1 = 4'hF;
    logic [3:0] r_d2 = 4'hF;
    logic [3:0] run_code = 4'hF;

    int n_vec = 0;
    int n_err = 0;

    int t2_idx [3] = '{0, 2, 10};
    int t2_val [3] = '{1, 3, 0};

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic one_low(input logic [3:0] code);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (!code[i]) n++;
        return (n == 1);
    endfunction

    // Observer: rebuilds what the scanner samples (row_in two cycles back, on tick
    // cycles) and logs every strobe with its cycle number.
    always @(negedge clk) begin
        logic [3:0] samp;
        logic       v;
        ev_t        e;
        int         nstb;
        if (reset) begin
            r_d1       = 4'hF;
            r_d2       = 4'hF;
            run        = 0;
            prev_valid = 1'b0;
        end else begin
            if (cyc % SCAN_DIV == SCAN_DIV - 1) begin
                samp = r_d2;
                v    = one_low(samp);
                if (v) begin
                    if (!prev_valid) onsetq.push_back(cyc);
                    if (run > 0 && samp == run_code) run++;
                    else begin
                        run      = 1;
                        run_code = samp;
                    end
                    if (run == DB) run3q.push_back(cyc);
                end else begin
                    run = 0;
                end
                prev_valid = v;
            end
            r_d2 = r_d1;
            r_d1 = row_in;
        end
        nstb = int'(digit_valid) + int'(start_key) + int'(stop_key);
        if (nstb > 1) multi_hits++;
        e.cyc = cyc;
        e.val = int'(set_time_digit);
        if (digit_valid) begin e.kind = 0; evq.push_back(e); end
        if (start_key)   begin e.kind = 1; evq.push_back(e); end
        if (stop_key)    begin e.kind = 2; evq.push_back(e); end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        evq.delete();
        onsetq.delete();
        run3q.delete();
    endtask

    task automatic press_release(input int idx, input int hold, input int gap);
        pressed[idx] = 1'b1;
        step(hold);
        pressed[idx] = 1'b0;
        step(gap);
    endtask

    task automatic check_one(input string tag, input int kind, input int val);
        check_val({tag, "_count"}, evq.size(), 1);
        if (evq.size() >= 1) begin
            check_val({tag, "_kind"}, evq[0].kind, kind);
            if (kind == 0) check_val({tag, "_value"}, evq[0].val, val);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_col"},   int'(col_out), 6);
        check_val({tag, "_digit"}, int'(set_time_digit), 15);
        check_val({tag, "_dv"},    int'(digit_valid), 0);
        check_val({tag, "_start"}, int'(start_key), 0);
        check_val({tag, "_stop"},  int'(stop_key), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int exp_col;

        pressed = '0;
        reset   = 1'b1;
        step(3);
        check_reset_outputs("rst");
        @(posedge clk);
        #2 reset = 1'b0;
        clear_log();

        // Idle keypad: column rotates every SCAN_DIV clocks, nothing is emitted.
        for (int k = 0; k < 28; k++) begin
            @(posedge clk);
            #1;
            c       = (cyc / 4) % 3;
            exp_col = (c == 0) ? 6 : (c == 1) ? 5 : 3;
            check_val("t1_col", int'(col_out), exp_col);
        end
        check_val("t1_no_strobe", evq.size(), 0);
        check_val("t1_digit", int'(set_time_digit), 15);

        for (int k = 0; k < 3; k++) begin
            clear_log();
            press_release(t2_idx[k], 40, 40);
            check_one("t2_key", 0, t2_val[k]);
            check_val("t2_onsets", onsetq.size(), 1);
            if (evq.size() >= 1 && onsetq.size() >= 1)
                check_val("t2_latency", evq[0].cyc - onsetq[0], 9);
        end

        clear_log();
        press_release(11, 60, 40);
        check_one("t3_hash", 1, 0);
        check_val("t3_digit_kept", int'(set_time_digit), 0);
        clear_log();
        press_release(9, 40, 40);
        check_one("t3_star", 2, 0);
        check_val("t3_digit_kept2", int'(set_time_digit), 0);

        clear_log();
        for (int k = 0; k < 3; k++) begin
            pressed[4] = 1'b1;
            step(5);
            pressed[4] = 1'b0;
            step(5);
        end
        press_release(4, 40, 40);
        check_one("t4_bounce", 0, 5);
        check_val("t4_stable_runs", run3q.size(), 1);
        if (evq.size() >= 1 && run3q.size() >= 1)
            check_val("t4_after_stable", evq[0].cyc - run3q[0], 1);

        clear_log();
        pressed[1] = 1'b1;
        pressed[7] = 1'b1;
        step(40);
        check_val("t5_both_held", evq.size(), 0);
        pressed[7] = 1'b0;
        step(40);
        check_one("t5_after_release", 0, 2);
        check_val("t5_stable_runs", run3q.size(), 1);
        if (evq.size() >= 1 && run3q.size() >= 1)
            check_val("t5_latency", evq[0].cyc - run3q[0], 1);
        pressed[1] = 1'b0;
        step(40);

        clear_log();
        pressed[8] = 1'b1;
        for (int k = 0; k < 40 && onsetq.size() == 0; k++) step(1);
        check_val("t6_onset_seen", int'(onsetq.size() > 0), 1);
        step(2);
        check_val("t6_no_early_strobe", evq.size(), 0);
        check_val("t6_digit_before", int'(set_time_digit), 2);
        check_val("t6_col_frozen", int'(col_out), 3);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        clear_log();
        step(30);
        check_one("t6_redetect", 0, 9);
        if (evq.size() >= 1)
            check_val("t6_strobe_cycle", evq[0].cyc, 20);
        pressed[8] = 1'b0;
        step(40);

        check_val("one_strobe_per_cycle", multi_hits, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_digit_scanner.md
# keypad_digit_scanner

- Scans the front-panel 4x3 membrane keypad and debounces it.
- Produces the key stream that top_microwave consumes:
  - one `set_time_digit` value per numeric press, marked by a one-cycle `digit_valid` strobe;
  - one-cycle `start_key` / `stop_key` strobes for the `#` and `*` keys.
- Sits between the keypad pins and the `set_time_digit` / `start` / `stop` inputs of top_microwave.
- Replaces the direct digit drive used in bench stimulus.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clocks per scan tick; must be at least 2.
- `DEBOUNCE_SCANS`, 4: consecutive stable scan ticks required to accept a press or a release; range 1..15.

Ports:
- `clk` input 1: system clock. Single clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `row_in` input 4: keypad rows, active-low, pulled up externally. Asynchronous to `clk`.
- `col_out` output 3: column drive, active-low one-hot.
- `set_time_digit` output 4: last accepted digit 0..9. `4'hF` when no digit has been accepted since reset.
- `digit_valid` output 1: one-cycle strobe; `set_time_digit` is updated on the same cycle.
- `start_key` output 1: one-cycle strobe on an accepted `#` press.
- `stop_key` output 1: one-cycle strobe on an accepted `*` press.

## Operation
Key map, as (row, col) → key:
- Row 0: (0,0)=1, (0,1)=2, (0,2)=3.
- Row 1: (1,0)=4, (1,1)=5, (1,2)=6.
- Row 2: (2,0)=7, (2,1)=8, (2,2)=9.
- Row 3: (3,0)=`*`, (3,1)=0, (3,2)=`#`.

Input path and scan tick:
- `row_in` passes through a 2-flop synchronizer before any use.
- A divider counts 0..SCAN_DIV-1. A scan tick occurs on the cycle the divider equals SCAN_DIV-1.

Sampling rule:
- A "sample" is the synchronized row code taken on a scan tick for the currently driven column.
- A sample is "valid" if exactly one row is low.
- A sample is "idle" if all rows are high.
- A sample with two or more rows low is neither valid nor idle.

State machine (SCAN, DEBOUNCE, HELD, RELEASE):
- SCAN
  - Idle sample: rotate column 0→1→2→0 and stay in SCAN.
  - Valid sample: latch row and column, set stable count = 1, go to DEBOUNCE. The column freezes.
  - Multi-row sample: rotate the column, stay in SCAN, emit nothing.
- DEBOUNCE
  - Sample equal to the latched row: increment the count. When the count reaches DEBOUNCE_SCANS, emit the key strobe and go to HELD.
  - Any other valid or multi-row sample: relatch if valid, otherwise keep the old latch; count = 1 if valid, 0 if multi-row. Stay in DEBOUNCE.
  - Idle sample: go to SCAN and rotate the column.
- HELD
  - The column stays frozen.
  - Idle sample: count = 1, go to RELEASE.
  - Any non-idle sample: stay in HELD. No auto-repeat.
- RELEASE
  - Idle sample: increment the count. At DEBOUNCE_SCANS, go to SCAN and rotate the column.
  - Non-idle sample: go to HELD. No new strobe.

Other rules:
- DEBOUNCE_SCANS = 1: strobe on the first valid sample; SCAN goes directly to HELD.
- Emission: digit keys load `set_time_digit` and pulse `digit_valid`; `#` pulses `start_key`; `*` pulses `stop_key`. Non-digit keys leave `set_time_digit` unchanged.
- At most one of the three strobes is high on any cycle.

## Timing
Reset values:
- `col_out` = 3'b110 (column 0 driven).
- `set_time_digit` = 4'hF.
- `digit_valid`, `start_key`, `stop_key` = 0.
- Divider, stable count and synchronizer = 0; state = SCAN.

Latency and clocking:
- A `row_in` change is visible to sampling 2 clocks later.
- Strobes are registered and assert on the cycle after the tick that completes debounce. They are high for exactly 1 clock.
- Column changes take effect on the cycle after the tick. The next sample of a column is one full SCAN_DIV period later, which gives the keypad settle time.
- Minimum accepted press, from first valid sample to strobe: (DEBOUNCE_SCANS-1)·SCAN_DIV + 1 clocks.

Reset behaviour:
- Reset asserted mid-debounce or mid-hold returns everything to reset values immediately.
- A key still held after reset releases is re-detected and re-emitted after a full debounce.

Other boundary rules:
- The divider free-runs in every state and wraps from SCAN_DIV-1 to 0.
- The stable count saturates at DEBOUNCE_SCANS.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3 and a behavioral keypad model.
1. Reset, idle rows → `col_out` rotates 110→101→011→110 every 4 clocks; `set_time_digit`=F; no strobes.
2. Press 1, 3, 0, each held 40 clocks with 40-clock gaps → exactly three `digit_valid` pulses with `set_time_digit` = 1, 3, 0. Each pulse lands 9 clocks after the first valid sample.
3. `#` held 60 clocks → one `start_key` pulse and no repeat; `set_time_digit` unchanged. Then `*` → one `stop_key` pulse.
4. Key 5 bouncing (toggle every 5 clocks for 30 clocks, then stable) → a single `digit_valid` with value 5, only after 3 consecutive stable samples.
5. Keys 2 and 8 pressed together → no strobe while both are held. Release 8 → `digit_valid` with value 2 after debounce.
6. Reset asserted while key 9 is in DEBOUNCE, key still held → outputs return to reset values asynchronously. After release of reset, one `digit_valid` with value 9.
